// File: rtl/card_pkg.sv
// Card codes and 7-segment patterns shared by
// the card encoder and the display monitor.
package card_pkg;

  typedef logic [3:0] card_t;
  typedef logic [6:0] seg_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_TWO   = 4'd2;
  localparam card_t CARD_THREE = 4'd3;
  localparam card_t CARD_FOUR  = 4'd4;
  localparam card_t CARD_FIVE  = 4'd5;
  localparam card_t CARD_SIX   = 4'd6;
  localparam card_t CARD_SEVEN = 4'd7;
  localparam card_t CARD_EIGHT = 4'd8;
  localparam card_t CARD_NINE  = 4'd9;
  localparam card_t CARD_TEN   = 4'd10;
  localparam card_t CARD_JACK  = 4'd11;
  localparam card_t CARD_QUEEN = 4'd12;
  localparam card_t CARD_KING  = 4'd13;
  localparam card_t CARD_BAD   = 4'd15;

  // Active-low segments, bit 6 = g .. bit 0 = a
  localparam seg_t SEG_EMPTY = 7'b1111111;
  localparam seg_t SEG_ACE   = 7'b0001000;
  localparam seg_t SEG_TWO   = 7'b0100100;
  localparam seg_t SEG_THREE = 7'b0110000;
  localparam seg_t SEG_FOUR  = 7'b0011001;
  localparam seg_t SEG_FIVE  = 7'b0010010;
  localparam seg_t SEG_SIX   = 7'b0000010;
  localparam seg_t SEG_SEVEN = 7'b1111000;
  localparam seg_t SEG_EIGHT = 7'b0000000;
  localparam seg_t SEG_NINE  = 7'b0010000;
  localparam seg_t SEG_TEN   = 7'b1000000;
  localparam seg_t SEG_JACK  = 7'b1100001;
  localparam seg_t SEG_QUEEN = 7'b0011000;
  localparam seg_t SEG_KING  = 7'b0001001;

  function automatic logic is_bad(card_t c);
    return c == CARD_BAD;
  endfunction

endpackage

// File: rtl/seg7_to_card.sv
// Combinational 7-segment pattern to card code
// decoder; unknown patterns map to CARD_BAD.
module seg7_to_card
  import card_pkg::*;
(
  input  logic [6:0] seg7,
  output logic [3:0] card
);

  // Table lookup, anything unlisted is bad
  always_comb begin
    card = CARD_BAD;
    case (seg7)
      SEG_EMPTY: card = CARD_EMPTY;
      SEG_ACE:   card = CARD_ACE;
      SEG_TWO:   card = CARD_TWO;
      SEG_THREE: card = CARD_THREE;
      SEG_FOUR:  card = CARD_FOUR;
      SEG_FIVE:  card = CARD_FIVE;
      SEG_SIX:   card = CARD_SIX;
      SEG_SEVEN: card = CARD_SEVEN;
      SEG_EIGHT: card = CARD_EIGHT;
      SEG_NINE:  card = CARD_NINE;
      SEG_TEN:   card = CARD_TEN;
      SEG_JACK:  card = CARD_JACK;
      SEG_QUEEN: card = CARD_QUEEN;
      SEG_KING:  card = CARD_KING;
      default:   card = CARD_BAD;
    endcase
  end

endmodule

// File: rtl/seg7_card_monitor.sv
// Debounces a multiplexed 7-seg bus per slot and
// publishes committed card changes as events.
module seg7_card_monitor
  import card_pkg::*;
#(
  parameter int NUM_SLOTS      = 6,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   seg_valid,
  input  logic [2:0]             seg_slot,
  input  logic [6:0]             seg7,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [2:0]             evt_slot,
  output logic [3:0]             evt_card,
  output logic                   evt_bad,
  output logic [4*NUM_SLOTS-1:0] slot_cards,
  output logic                   overrun
);

  localparam logic [3:0] STABLE =
    4'(STABLE_SAMPLES);

  typedef logic [NUM_SLOTS-1:0][3:0] tab_t;

  logic [3:0] code;

  tab_t cand_q, cand_d;
  tab_t cnt_q, cnt_d;
  tab_t card_q, card_d;

  logic       hit;
  logic       commit;
  logic [2:0] c_slot;
  logic [3:0] c_card;

  logic       evt_valid_q, evt_valid_d;
  logic [2:0] evt_slot_q, evt_slot_d;
  logic [3:0] evt_card_q, evt_card_d;
  logic       evt_bad_q, evt_bad_d;
  logic       overrun_q, overrun_d;
  logic       hs;

  seg7_to_card u_dec (
    .seg7 (seg7),
    .card (code)
  );

  // Per-slot candidate/counter debounce and commit
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    card_d = card_q;
    hit    = 1'b0;
    commit = 1'b0;
    c_slot = '0;
    c_card = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (seg_valid && seg_slot == 3'(s)) begin
        if (code == cand_q[s]) begin
          if (cnt_q[s] != STABLE)
            cnt_d[s] = cnt_q[s] + 4'd1;
          hit = (cnt_q[s] == STABLE - 4'd1);
        end else begin
          cand_d[s] = code;
          cnt_d[s]  = 4'd1;
          hit       = (STABLE == 4'd1);
        end
        if (hit && cand_d[s] != card_q[s]) begin
          commit    = 1'b1;
          card_d[s] = cand_d[s];
          c_slot    = 3'(s);
          c_card    = cand_d[s];
        end
      end
    end
  end

  // Single-entry event register with overrun flag
  always_comb begin
    hs          = evt_valid_q & evt_ready;
    evt_valid_d = evt_valid_q;
    evt_slot_d  = evt_slot_q;
    evt_card_d  = evt_card_q;
    evt_bad_d   = evt_bad_q;
    overrun_d   = overrun_q;
    if (commit) begin
      if (!evt_valid_q || hs) begin
        evt_valid_d = 1'b1;
        evt_slot_d  = c_slot;
        evt_card_d  = c_card;
        evt_bad_d   = is_bad(c_card);
      end else begin
        overrun_d = 1'b1;
      end
    end else if (hs) begin
      evt_valid_d = 1'b0;
    end
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetb) begin
      cand_q      <= '0;
      cnt_q       <= '0;
      card_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_slot_q  <= '0;
      evt_card_q  <= '0;
      evt_bad_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      card_q      <= card_d;
      evt_valid_q <= evt_valid_d;
      evt_slot_q  <= evt_slot_d;
      evt_card_q  <= evt_card_d;
      evt_bad_q   <= evt_bad_d;
      overrun_q   <= overrun_d;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_slot   = evt_slot_q;
  assign evt_card   = evt_card_q;
  assign evt_bad    = evt_bad_q;
  assign slot_cards = card_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_seg7_card_monitor.sv
// Self-checking bench for seg7_card_monitor:
// history-queue model plus literal checks.
module tb_seg7_card_monitor;

  localparam int NUM = 6;
  localparam int STB = 4;

  logic           clk = 1'b0;
  logic           resetb = 1'b0;
  logic           seg_valid = 1'b0;
  logic [2:0]     seg_slot = '0;
  logic [6:0]     seg7 = 7'h7f;
  logic           evt_valid;
  logic           evt_ready = 1'b1;
  logic [2:0]     evt_slot;
  logic [3:0]     evt_card;
  logic           evt_bad;
  logic [4*NUM-1:0] slot_cards;
  logic           overrun;

  int total = 0;
  int bad = 0;

  seg7_card_monitor #(
    .NUM_SLOTS      (NUM),
    .STABLE_SAMPLES (STB)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .seg_valid  (seg_valid),
    .seg_slot   (seg_slot),
    .seg7       (seg7),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_slot   (evt_slot),
    .evt_card   (evt_card),
    .evt_bad    (evt_bad),
    .slot_cards (slot_cards),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // reference table, index = card code
  logic [6:0] pat [14] = '{
    7'b1111111, 7'b0001000, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000, 7'b1000000, 7'b1100001,
    7'b0011000, 7'b0001001
  };

  int hist [NUM][$];
  int m_cards [NUM] = '{default: 0};
  bit m_valid = 0;
  int m_slot = 0;
  int m_card = 0;
  bit m_bad = 0;
  bit m_ovr = 0;

  function automatic int ref_dec(logic [6:0] p);
    for (int i = 0; i < 14; i++)
      if (pat[i] == p) return i;
    return 15;
  endfunction

  function automatic int run_len(int s);
    int n = 0;
    int sz = hist[s].size();
    for (int i = sz - 1; i >= 0; i--) begin
      if (hist[s][i] != hist[s][sz-1]) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [4*NUM-1:0] m_vec();
    logic [4*NUM-1:0] v = '0;
    for (int s = 0; s < NUM; s++)
      v[4*s +: 4] = 4'(m_cards[s]);
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // behavioural model: commit when the trailing run
  // of identical samples is exactly STB long
  always @(posedge clk) begin
    bit cm;
    int cs, cc, d;
    bit hs;
    cm = 0; cs = 0; cc = 0;
    if (!resetb) begin
      for (int s = 0; s < NUM; s++) begin
        hist[s].delete();
        m_cards[s] = 0;
      end
      m_valid = 0; m_slot = 0; m_card = 0;
      m_bad = 0; m_ovr = 0;
    end else begin
      if (seg_valid && int'(seg_slot) < NUM) begin
        cs = int'(seg_slot);
        d = ref_dec(seg7);
        hist[cs].push_back(d);
        if (hist[cs].size() > 20)
          void'(hist[cs].pop_front());
        if (run_len(cs) == STB && d != m_cards[cs]) begin
          cm = 1;
          cc = d;
          m_cards[cs] = d;
        end
      end
      hs = m_valid && evt_ready;
      if (cm) begin
        if (!m_valid || hs) begin
          m_valid = 1; m_slot = cs;
          m_card = cc; m_bad = (cc == 15);
        end else begin
          m_ovr = 1;
        end
      end else if (hs) begin
        m_valid = 0;
      end
    end
  end

  // compare process, every cycle on the falling edge
  always @(negedge clk) begin
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    chk("evt_slot", 32'(evt_slot), 32'(m_slot));
    chk("evt_card", 32'(evt_card), 32'(m_card));
    chk("evt_bad", 32'(evt_bad), 32'(m_bad));
    chk("slot_cards", 32'(slot_cards), 32'(m_vec()));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  end

  task automatic smp(int slot, logic [6:0] p, int n);
    for (int i = 0; i < n; i++) begin
      seg_valid = 1'b1;
      seg_slot  = 3'(slot);
      seg7      = p;
      @(posedge clk); #2;
    end
    seg_valid = 1'b0;
  endtask

  task automatic idle(int n);
    seg_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
    end
  endtask

  logic [4*NUM-1:0] saved;
  int evts;

  initial begin
    resetb = 1'b0;
    idle(2);
    resetb = 1'b1;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_cards", 32'(slot_cards), 0);
    chk("rst_ovr", 32'(overrun), 0);

    smp(0, 7'b0100100, 3);
    chk("s0_3smp", 32'(evt_valid), 0);
    smp(0, 7'b0100100, 1);
    chk("s0_valid", 32'(evt_valid), 1);
    chk("s0_slot", 32'(evt_slot), 0);
    chk("s0_card", 32'(evt_card), 2);
    chk("s0_tab", 32'(slot_cards[3:0]), 2);
    idle(1);
    chk("s0_taken", 32'(evt_valid), 0);

    evts = 0;
    for (int i = 0; i < 7; i++) begin
      smp(1, i < 3 ? 7'b0110000 : 7'b0011001, 1);
      if (evt_valid) evts++;
    end
    chk("s1_events", 32'(evts), 1);
    chk("s1_card", 32'(evt_card), 4);
    chk("s1_tab", 32'(slot_cards[7:4]), 4);

    saved = slot_cards;
    smp(0, 7'b0100100, 10);
    chk("s0_hold_v", 32'(evt_valid), 0);
    chk("s0_hold_t", 32'(slot_cards), 32'(saved));

    evt_ready = 1'b0;
    smp(2, 7'b0001001, 4);
    smp(3, 7'b0011000, 4);
    chk("bp_slot", 32'(evt_slot), 2);
    chk("bp_card", 32'(evt_card), 13);
    chk("bp_ovr", 32'(overrun), 1);
    chk("bp_t2", 32'(slot_cards[11:8]), 13);
    chk("bp_t3", 32'(slot_cards[15:12]), 12);
    evt_ready = 1'b1;
    idle(1);
    chk("bp_drain", 32'(evt_valid), 0);

    smp(4, 7'b1111110, 4);
    chk("bad_card", 32'(evt_card), 15);
    chk("bad_flag", 32'(evt_bad), 1);
    saved = slot_cards;
    smp(6, 7'b0000000, 4);
    smp(7, 7'b0010000, 4);
    seg_slot = 3'd5; seg7 = 7'b0000010;
    idle(4);
    chk("ign_tab", 32'(slot_cards), 32'(saved));
    chk("ign_ovr", 32'(overrun), 1);

    smp(5, 7'b1111000, 3);
    resetb = 1'b0;
    idle(1);
    resetb = 1'b1;
    smp(5, 7'b1111000, 1);
    chk("rst2_valid", 32'(evt_valid), 0);
    chk("rst2_tab", 32'(slot_cards), 0);
    chk("rst2_ovr", 32'(overrun), 0);
    chk("rst2_card", 32'(evt_card), 0);
    idle(5);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_card_monitor.md
Name: seg7_card_monitor

Overview:
- Receive-side counterpart of the card-to-7-segment encoder.
- Watches a time-multiplexed 7-segment bus (active-low segments, one digit slot per sample) and decodes each pattern back to a 4-bit card code.
- Each slot's value is debounced; a change event is published over a valid/ready handshake.
- Used by the self-checking display monitor and the scoring logic to read back the six card slots (player and dealer, 3 each).

Parameters:
- NUM_SLOTS, 6, number of digit slots tracked (slot index 0..NUM_SLOTS-1).
- STABLE_SAMPLES, 4, consecutive identical samples required before a slot's value is committed (legal range 1..15).

Ports:
- clk  input  1  system clock.
- resetb  input  1  synchronous, active-low reset.
- seg_valid  input  1  seg7/seg_slot carry a sample this cycle.
- seg_slot  input  3  slot index of the sample.
- seg7  input  7  active-low segment pattern, bit 6 = g … bit 0 = a.
- evt_valid  output  1  change event available.
- evt_ready  input  1  consumer accepts the event.
- evt_slot  output  3  slot that changed.
- evt_card  output  4  new committed card code.
- evt_bad  output  1  new code is CARD_BAD.
- slot_cards  output  4*NUM_SLOTS  committed code per slot; slot s occupies bits [4s+3:4s].
- overrun  output  1  sticky: an event was lost to backpressure.

Behaviour:
- One clock (clk). Reset is synchronous, active-low (resetb) and dominates all other inputs. Asserting it mid-count or mid-handshake discards everything in the same edge.
- Reset values: slot_cards=0, evt_valid=0, evt_slot=0, evt_card=0, evt_bad=0, overrun=0. All internal candidate codes and counters are cleared to 0.
- Decode table (combinational):
  - 1111111 -> 0 (EMPTY)
  - 0001000 -> 1 (ace)
  - 0100100 -> 2
  - 0110000 -> 3
  - 0011001 -> 4
  - 0010010 -> 5
  - 0000010 -> 6
  - 1111000 -> 7
  - 0000000 -> 8
  - 0010000 -> 9
  - 1000000 -> 10
  - 1100001 -> 11 (jack)
  - 0011000 -> 12 (queen)
  - 0001001 -> 13 (king)
  - any other pattern -> 15 (CARD_BAD)
- Samples with seg_valid=0 or seg_slot>=NUM_SLOTS are ignored; no state changes.
- Per-slot debounce, on an accepted sample for slot s with decoded code d:
  - If d==cand[s]: cnt[s] increments, saturating at STABLE_SAMPLES.
  - Otherwise: cand[s]<=d and cnt[s]<=1.
- Commit occurs when cnt[s] reaches STABLE_SAMPLES on this sample, i.e. the transition, not while held at saturation, and cand[s] differs from the committed code.
  - slot_cards[s] updates and an event is generated on that same edge.
  - Latency: 1 cycle after the STABLE_SAMPLES-th sample, the new values are visible.
  - With STABLE_SAMPLES=1, any single differing sample commits.
- No event is generated when the stabilized value equals the committed value. Blank digits after reset therefore produce no events.
- Event register is single-entry:
  - While evt_valid=1 and evt_ready=0, evt_slot/evt_card/evt_bad hold stable.
  - A handshake occurs on a cycle where evt_valid&evt_ready=1.
  - If a new commit coincides with a handshake, the register loads the new event and evt_valid stays 1.
  - If a new commit arrives while the register is full and not being handshaken, the new event is dropped and overrun<=1. slot_cards still updates.
  - overrun is cleared only by reset.
- evt_bad = (evt_card==15), registered together with evt_card.
- Only one sample per cycle, so at most one commit per cycle.

Decomposition:
- Package card_pkg holds:
  - Card code constants: CARD_EMPTY=0, CARD_ACE=1 … CARD_KING=13, CARD_BAD=15.
  - The 14 segment-pattern constants, shared with the encoder so both directions use one table.
- One combinational sub-module, seg7_to_card (seg7 in, 4-bit code out), implements the decode table.
- seg7_card_monitor owns all sequential logic: candidate/counter arrays, committed table, event register.

Test Plan:
- Reset; slot 0 driven 0100100 ×4 with evt_ready=1 -> one cycle after 4th sample: evt_valid=1, evt_slot=0, evt_card=2, slot_cards[3:0]=2; nothing after 3 samples.
- Slot 1: 0110000 ×3, 0011001 ×4 -> exactly one event (slot 1, card 4); no event for 3.
- Slot 0 held at 0100100 ×10 after commit -> no further events; slot_cards unchanged.
- evt_ready=0: commit slot 2 king (0001001), then slot 3 queen (0011000) -> evt holds slot 2/13; overrun=1; slot_cards shows 13 and 12. Raise evt_ready -> event consumed, evt_valid=0.
- Slot 4: 1111110 ×4 -> evt_card=15, evt_bad=1. Then seg_slot=6 samples -> ignored, no state change.
- Slot 5: 1011... pattern 1111000 ×3, resetb=0 one cycle, then 1 sample -> no event; all outputs 0 after reset.
